// File: rtl/frac_clk_en_gen_if.sv
// Config and output bundle of frac_clk_en_gen.
// Latency: none (wires only).
// Backpressure: cfg_valid/cfg_ready handshake; the outputs have no backpressure.
//
// Signals:
//   cfg_valid  master->slave  config request
//   cfg_ready  slave->master  config accept (a transfer is cfg_valid && cfg_ready)
//   cfg_ch     master->slave  target channel index
//   cfg_incr   master->slave  new phase increment (0 stops the channel)
//   outclk_en  slave->master  per-channel single-cycle enable pulse
//   outclk_sq  slave->master  per-channel approximate square wave
//   locked     slave->master  outputs valid and stable
interface frac_clk_en_gen_if #(
  parameter int NUM_CH = 4,
  parameter int ACC_W  = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [ACC_W-1:0]  cfg_incr;
  logic [NUM_CH-1:0] outclk_en;
  logic [NUM_CH-1:0] outclk_sq;
  logic              locked;

  modport master (
    output cfg_valid, cfg_ch, cfg_incr,
    input  cfg_ready, outclk_en, outclk_sq, locked
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_incr,
    output cfg_ready, outclk_en, outclk_sq, locked
  );
endinterface

// File: rtl/frac_clk_en_gen.sv
// Multi-channel phase-accumulator clock-enable generator with a PLL-like lock FSM.
// Latency: every output is registered; a reprogram relocks LOCK_CYCLES+1 edges after the transfer edge.
// Backpressure: cfg_ready is low in IDLE and UPDATE, so accepted valid transfers are spaced by at least 2 cycles.
//
// Ports:
//   refclk  the single clock, rising edge
//   rst_n   asynchronous active-low reset
//   cfg_if  slave side of frac_clk_en_gen_if (config handshake, outclk_en, outclk_sq, locked)
module frac_clk_en_gen #(
  parameter int               NUM_CH       = 4,
  parameter int               ACC_W        = 16,
  parameter logic [ACC_W-1:0] DEFAULT_INCR = 16'h8000,
  parameter int               LOCK_CYCLES  = 16
) (
  input  logic             refclk,
  input  logic             rst_n,
  frac_clk_en_gen_if.slave cfg_if
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LC_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LC_W-1:0] LC_LAST = LC_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOCKING = 2'd1,
    S_UPDATE  = 2'd2,
    S_LOCKED  = 2'd3
  } state_t;

  state_t                        state_q;
  logic [LC_W-1:0]               lock_cnt_q;
  logic [NUM_CH-1:0][ACC_W-1:0]  incr_q;
  logic [NUM_CH-1:0][ACC_W-1:0]  acc_q;
  logic [NUM_CH-1:0]             en_q;
  logic [NUM_CH-1:0]             sq_q;
  logic                          locked_q;
  logic                          ready_q;

  logic                          ch_ok;
  logic                          xfer_ok;
  logic [NUM_CH-1:0][ACC_W:0]    acc_d;

  // An index range that exactly fills CH_W bits can never be out of range.
  generate
    if (NUM_CH == (1 << CH_W)) begin : g_all_valid
      assign ch_ok = 1'b1;
    end else begin : g_range_chk
      localparam logic [CH_W-1:0] NUM_CH_C = CH_W'(NUM_CH);
      assign ch_ok = (cfg_if.cfg_ch < NUM_CH_C);
    end
  endgenerate

  // Transfers to a nonexistent channel are accepted (ready is honoured) but ignored.
  assign xfer_ok = cfg_if.cfg_valid && ready_q && ch_ok;

  // Wide sum: bit ACC_W is the carry that becomes the enable pulse.
  always_comb begin
    acc_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      acc_d[i] = {1'b0, acc_q[i]} + {1'b0, incr_q[i]};
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      lock_cnt_q <= '0;
      incr_q     <= {NUM_CH{DEFAULT_INCR}};
      acc_q      <= '0;
      en_q       <= '0;
      sq_q       <= '0;
      locked_q   <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q    <= S_LOCKING;
          lock_cnt_q <= '0;
          ready_q    <= 1'b1;
        end
        S_LOCKING: begin
          if (xfer_ok) begin
            state_q <= S_UPDATE;
            ready_q <= 1'b0;
          end else if (lock_cnt_q == LC_LAST) begin
            state_q  <= S_LOCKED;
            locked_q <= 1'b1;
          end else begin
            lock_cnt_q <= lock_cnt_q + 1'b1;
          end
        end
        S_UPDATE: begin
          state_q    <= S_LOCKING;
          lock_cnt_q <= '0;
          ready_q    <= 1'b1;
        end
        default: begin // S_LOCKED
          if (xfer_ok) begin
            state_q  <= S_UPDATE;
            ready_q  <= 1'b0;
            locked_q <= 1'b0;
          end
        end
      endcase

      for (int i = 0; i < NUM_CH; i++) begin
        if (xfer_ok && (cfg_if.cfg_ch == CH_W'(i))) begin
          incr_q[i] <= cfg_if.cfg_incr;
        end
        // Holding every accumulator at 0 outside LOCKED phase-aligns all channels on relock.
        if (state_q == S_LOCKED) begin
          acc_q[i] <= acc_d[i][ACC_W-1:0];
          en_q[i]  <= acc_d[i][ACC_W];
          sq_q[i]  <= acc_d[i][ACC_W-1];
        end else begin
          acc_q[i] <= '0;
          en_q[i]  <= 1'b0;
          sq_q[i]  <= 1'b0;
        end
      end
    end
  end

  assign cfg_if.cfg_ready = ready_q;
  assign cfg_if.outclk_en = en_q;
  assign cfg_if.outclk_sq = sq_q;
  assign cfg_if.locked    = locked_q;

endmodule

// File: tb/tb_frac_clk_en_gen.sv
// Bench for frac_clk_en_gen: two instances (default 4ch/16b/16 and a 3ch/8b/5 variant that
// can address a nonexistent channel), directed test-plan sequences then random traffic,
// every cycle compared against a countdown/arithmetic reference model.
module tb_frac_clk_en_gen;
  localparam int NA = 4, WA = 16, LCA = 16;
  localparam int NB = 3, WB = 8,  LCB = 5;

  logic refclk = 1'b0;
  logic rst_n  = 1'b1;
  always #5 refclk = ~refclk;

  frac_clk_en_gen_if #(.NUM_CH(NA), .ACC_W(WA)) ifa ();
  frac_clk_en_gen_if #(.NUM_CH(NB), .ACC_W(WB)) ifb ();

  frac_clk_en_gen #(.NUM_CH(NA), .ACC_W(WA), .DEFAULT_INCR(16'h8000), .LOCK_CYCLES(LCA)) u_dut_a (
    .refclk(refclk), .rst_n(rst_n), .cfg_if(ifa)
  );
  frac_clk_en_gen #(.NUM_CH(NB), .ACC_W(WB), .DEFAULT_INCR(8'h40), .LOCK_CYCLES(LCB)) u_dut_b (
    .refclk(refclk), .rst_n(rst_n), .cfg_if(ifb)
  );

  // Reference model state, one slot per instance.
  int              p_n [2] = '{NA, NB};
  int              p_w [2] = '{WA, WB};
  int              p_lc[2] = '{LCA, LCB};
  longint unsigned p_def[2] = '{64'h8000, 64'h40};

  longint unsigned m_acc [2][4];
  longint unsigned m_incr[2][4];
  int              m_wait[2];   // edges still to go before locked; 0 = locked
  int              m_en[2], m_sq[2];
  bit              m_lock[2], m_rdy[2];

  bit              s_vld[2];
  int              s_ch[2];
  longint unsigned s_incr[2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input int k, input bit vld, input int ch, input longint unsigned incr);
    s_vld[k]  = vld;
    s_ch[k]   = ch & 3;
    s_incr[k] = incr & ((64'd1 << p_w[k]) - 1);
    if (k == 0) begin
      ifa.cfg_valid = vld; ifa.cfg_ch = 2'(ch); ifa.cfg_incr = 16'(incr);
    end else begin
      ifb.cfg_valid = vld; ifb.cfg_ch = 2'(ch); ifb.cfg_incr = 8'(incr);
    end
  endtask

  task automatic model_reset(input int k);
    for (int c = 0; c < 4; c++) begin
      m_acc[k][c]  = 0;
      m_incr[k][c] = p_def[k];
    end
    m_wait[k] = 1 + p_lc[k];
    m_en[k] = 0; m_sq[k] = 0; m_lock[k] = 0; m_rdy[k] = 0;
  endtask

  // One rising edge: rate outputs from the pre-edge state, then apply any accepted transfer.
  task automatic model_step(input int k);
    bit pre_rdy;
    longint unsigned mask, s;
    int en, sq;
    pre_rdy = (m_wait[k] <= p_lc[k]);
    mask = (64'd1 << p_w[k]) - 1;
    en = 0; sq = 0;
    for (int c = 0; c < p_n[k]; c++) begin
      if (m_wait[k] == 0) begin
        s = m_acc[k][c] + m_incr[k][c];
        if (s > mask) en |= (1 << c);
        m_acc[k][c] = s & mask;
        if (((m_acc[k][c] >> (p_w[k] - 1)) & 1) != 0) sq |= (1 << c);
      end else begin
        m_acc[k][c] = 0;
      end
    end
    m_en[k] = en; m_sq[k] = sq;
    if (s_vld[k] && pre_rdy && (s_ch[k] < p_n[k])) begin
      m_incr[k][s_ch[k]] = s_incr[k];
      m_wait[k] = 1 + p_lc[k];
    end else if (m_wait[k] > 0) begin
      m_wait[k]--;
    end
    m_lock[k] = (m_wait[k] == 0);
    m_rdy[k]  = (m_wait[k] <= p_lc[k]);
  endtask

  task automatic compare_all();
    check_eq("a_en",    longint'(ifa.outclk_en), longint'(m_en[0]));
    check_eq("a_sq",    longint'(ifa.outclk_sq), longint'(m_sq[0]));
    check_eq("a_lock",  longint'(ifa.locked),    longint'(m_lock[0]));
    check_eq("a_ready", longint'(ifa.cfg_ready), longint'(m_rdy[0]));
    check_eq("b_en",    longint'(ifb.outclk_en), longint'(m_en[1]));
    check_eq("b_sq",    longint'(ifb.outclk_sq), longint'(m_sq[1]));
    check_eq("b_lock",  longint'(ifb.locked),    longint'(m_lock[1]));
    check_eq("b_ready", longint'(ifb.cfg_ready), longint'(m_rdy[1]));
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (rst_n) model_step(k);
      else       model_reset(k);
    end
    compare_all();
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    compare_all();
    tick();
    rst_n = 1'b1;
  endtask

  // Edge numbers (from reset release) of first locked and first ch0 pulse on both instances.
  task automatic lock_check(input string tag);
    int fl_a, fe_a, fl_b, fe_b;
    fl_a = 0; fe_a = 0; fl_b = 0; fe_b = 0;
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (ifa.locked && fl_a == 0)       fl_a = e;
      if (ifa.outclk_en[0] && fe_a == 0) fe_a = e;
      if (ifb.locked && fl_b == 0)       fl_b = e;
      if (ifb.outclk_en[0] && fe_b == 0) fe_b = e;
    end
    check_eq({tag, "_a_lock_edge"}, fl_a, 17);
    check_eq({tag, "_a_en_edge"},   fe_a, 19);
    check_eq({tag, "_b_lock_edge"}, fl_b, 6);
    check_eq({tag, "_b_en_edge"},   fe_b, 10);
  endtask

  function automatic longint unsigned pick_incr(input int k);
    longint unsigned mask;
    mask = (64'd1 << p_w[k]) - 1;
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return mask;
      2:       return p_def[k];
      3:       return longint'($urandom_range(1, 7)) << (p_w[k] - 3);
      4:       return longint'($urandom) & mask;
      default: return longint'($urandom_range(1, 40));
    endcase
  endfunction

  initial begin
    int acc_cnt, lows, ch1_any, wait_n;
    int rl, c2, c0;

    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    #1;
    assert_reset();          // reset values, then one edge held in reset
    lock_check("init");

    // Reprogram ch2 on A to 0x5555: relock and 4-cycle first pulse.
    drive(0, 1, 2, 'h5555);
    tick();
    drive(0, 0, 0, 0);
    rl = 0; c2 = 0; c0 = 0;
    for (int e = 1; e <= 80; e++) begin
      tick();
      if (ifa.locked && rl == 0)        rl = e;
      if (ifa.outclk_en[2] && c2 == 0)  c2 = e;
      if (ifa.outclk_en[0] && c0 == 0)  c0 = e;
    end
    check_eq("reprog_lock_edge", rl, 17);
    check_eq("reprog_ch2_first", c2, 21);
    check_eq("reprog_ch0_first", c0, 19);

    // Hold cfg_valid across UPDATE: two acceptances in three cycles; ch1 stopped.
    drive(0, 1, 1, 0);
    acc_cnt = 0;
    for (int e = 0; e < 3; e++) begin
      if (ifa.cfg_ready) acc_cnt++;
      tick();
    end
    drive(0, 0, 0, 0);
    check_eq("held_valid_accepts", acc_cnt, 2);
    ch1_any = 0;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (ifa.outclk_en[1] || ifa.outclk_sq[1]) ch1_any++;
    end
    check_eq("stopped_ch1_activity", ch1_any, 0);

    // Invalid channel on B: accepted, no relock.
    drive(1, 1, 3, 'h11);
    tick();
    drive(1, 0, 0, 0);
    check_eq("invalid_ch_still_locked", longint'(ifb.locked), 1);
    tick();

    // Max increment on B ch0: one low cycle per 256 locked cycles.
    drive(1, 1, 0, 'hFF);
    tick();
    drive(1, 0, 0, 0);
    wait_n = 0;
    while (!ifb.locked && wait_n < 20) begin
      tick();
      wait_n++;
    end
    check_eq("b_relock_timeout", longint'(ifb.locked), 1);
    lows = 0;
    for (int e = 0; e < 512; e++) begin
      tick();
      if (!ifb.outclk_en[0]) lows++;
    end
    check_eq("b_max_rate_lows", lows, 2);

    // Reset mid-LOCKING after a ch0 write; defaults return.
    drive(0, 1, 0, 'h1000);
    tick();
    drive(0, 0, 0, 0);
    repeat (5) tick();
    assert_reset();
    lock_check("post_rst");

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 12000; i++) begin
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 39) == 0)
          drive(k, 1, int'($urandom_range(0, 3)), pick_incr(k));
        else
          drive(k, 0, 0, 0);
      end
      if ($urandom_range(0, 2999) == 0) assert_reset();
      else tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
